// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for an 8-entry dual-port FIFO RAM (control only, no data path).
// Optional high-water-mark output peak_count enabled by defining FIFO_CTRL_PEAK_EN.
module fifo_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned AF_TH  = 6,
  parameter int unsigned AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_valid,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow_err,
  output logic              underflow_err
`ifdef FIFO_CTRL_PEAK_EN
  ,
  output logic [PTR_W:0]    peak_count
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_acc, pop_acc;

  always_comb begin
    pop_acc  = pop & (state_q != OCC_FULL ? (state_q != OCC_EMPTY) : 1'b1);
    // Push at full only goes through when a pop frees the slot in the same cycle.
    push_acc = push & ((state_q != OCC_FULL) | pop_acc);
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    state_d    = state_q;
    rd_valid_d = pop_acc;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (push_acc) wptr_d = wptr_q + PTR_W'(1);
    if (pop_acc)  rptr_d = rptr_q + PTR_W'(1);
    if (push_acc && !pop_acc) count_d = count_q + ONE_C;
    if (pop_acc && !push_acc) count_d = count_q - ONE_C;

    unique case (state_q)
      OCC_EMPTY:   if (push_acc) state_d = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (count_q == LAST_C && push_acc && !pop_acc)     state_d = OCC_FULL;
        else if (count_q == ONE_C && pop_acc && !push_acc) state_d = OCC_EMPTY;
      end
      OCC_FULL:    if (pop_acc && !push_acc) state_d = OCC_PARTIAL;
      default:     state_d = OCC_EMPTY;
    endcase

    // A new error in the same cycle as err_clr must stick.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push && !push_acc)           ovf_d = 1'b1;
    if (pop && state_q == OCC_EMPTY) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= OCC_EMPTY;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

`ifdef FIFO_CTRL_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (err_clr || count_q > peak_q) peak_d = count_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

  always_comb begin
    ram_we        = push_acc;
    ram_re        = pop_acc;
    ram_waddr     = ADDR_W'(wptr_q);
    ram_raddr     = ADDR_W'(rptr_q);
    rd_valid      = rd_valid_q;
    count         = count_q;
    full          = (state_q == OCC_FULL);
    empty         = (state_q == OCC_EMPTY);
    almost_full   = (count_q >= AF_C);
    almost_empty  = (count_q <= AE_C);
    overflow_err  = ovf_q;
    underflow_err = unf_q;
  end

  initial assert (DEPTH == (1 << PTR_W) && ADDR_W >= PTR_W && DEPTH <= 16);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: fill/drain, boundaries, wrap, async reset, sticky errors.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push, pop, err_clr;
  logic       ram_we, ram_re, rd_valid;
  logic [3:0] ram_waddr, ram_raddr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic       overflow_err, underflow_err;
`ifdef FIFO_CTRL_PEAK_EN
  logic [3:0] peak_count;
`endif

  int total = 0;
  int bad   = 0;

  fifo_ctrl #(.DEPTH(8), .PTR_W(3), .ADDR_W(4), .AF_TH(6), .AE_TH(2)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .err_clr      (err_clr),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
`ifdef FIFO_CTRL_PEAK_EN
    ,
    .peak_count   (peak_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-low-phase, settle combinational outputs.
  task automatic cyc(input logic p, input logic q, input logic c);
    @(negedge clk);
    push = p; pop = q; err_clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 0; pop = 0; err_clr = 0;
    reset_L = 0;
    #2;
    reset_L = 1;
  endtask

  initial begin
    reset_L = 0; push = 0; pop = 0; err_clr = 0;
    #12 reset_L = 1;

    // Reset state after idle
    repeat (5) tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);
    chk("rst_rdv", rd_valid, 0);

    // 8 pushes from empty
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      chk("fill_we", ram_we, 1);
      chk("fill_waddr", ram_waddr, i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 6);
      chk("fill_ae", almost_empty, (i + 1) <= 2);
      chk("fill_full", full, (i + 1) == 8);
      chk("fill_empty", empty, 0);
    end
    cyc(1, 0, 0);
    chk("ovf_we", ram_we, 0);
    chk("ovf_waddr", ram_waddr, 0);
    tick();
    chk("ovf_err", overflow_err, 1);
    chk("ovf_count", count, 8);
    cyc(0, 0, 1);
    tick();
    chk("ovf_clr", overflow_err, 0);

    // 8 pops to empty
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      chk("drain_re", ram_re, 1);
      chk("drain_raddr", ram_raddr, i);
      chk("drain_rdv_pre", rd_valid, i > 0);
      tick();
      chk("drain_rdv", rd_valid, 1);
      chk("drain_count", count, 7 - i);
      chk("drain_empty", empty, i == 7);
      chk("drain_full", full, 0);
    end
    cyc(0, 1, 0);
    chk("unf_re", ram_re, 0);
    tick();
    chk("unf_rdv", rd_valid, 0);
    chk("unf_err", underflow_err, 1);
    chk("unf_count", count, 0);
    cyc(0, 0, 1);
    tick();
    chk("unf_clr", underflow_err, 0);

    // Push+pop at full
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      tick();
    end
    chk("pp_full_pre", full, 1);
    cyc(1, 1, 0);
    chk("ppf_we", ram_we, 1);
    chk("ppf_re", ram_re, 1);
    chk("ppf_waddr", ram_waddr, 0);
    chk("ppf_raddr", ram_raddr, 0);
    tick();
    chk("ppf_count", count, 8);
    chk("ppf_full", full, 1);
    chk("ppf_ovf", overflow_err, 0);
    chk("ppf_rdv", rd_valid, 1);
    cyc(0, 0, 0);
    chk("ppf_wptr", ram_waddr, 1);
    chk("ppf_rptr", ram_raddr, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      chk("ppd_raddr", ram_raddr, (i + 1) % 8);
      tick();
    end
    chk("ppd_empty", empty, 1);

    // Push+pop at empty
    cyc(1, 1, 0);
    chk("ppe_we", ram_we, 1);
    chk("ppe_re", ram_re, 0);
    tick();
    chk("ppe_count", count, 1);
    chk("ppe_unf", underflow_err, 1);
    chk("ppe_rdv", rd_valid, 0);
    chk("ppe_empty", empty, 0);

    // Wrap: two blocks of push 6 / pop 6 from pointers at 0
    do_reset();
    chk("wrap_rst_unf", underflow_err, 0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6; i++) begin
        cyc(1, 0, 0);
        chk("wrap_waddr", ram_waddr, (b * 6 + i) % 8);
        tick();
      end
      chk("wrap_count6", count, 6);
      chk("wrap_af", almost_full, 1);
      for (int i = 0; i < 6; i++) begin
        cyc(0, 1, 0);
        chk("wrap_raddr", ram_raddr, (b * 6 + i) % 8);
        tick();
      end
      chk("wrap_count0", count, 0);
      chk("wrap_empty", empty, 1);
    end

    // Async reset between edges at count=5
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      tick();
    end
    cyc(0, 1, 0);
    tick();
    cyc(1, 0, 0);
    tick();
    chk("ar_pre_count", count, 5);
    chk("ar_pre_rdv", rd_valid, 0);
    push = 0;
    #2 reset_L = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_ae", almost_empty, 1);
    chk("ar_af", almost_full, 0);
    chk("ar_waddr", ram_waddr, 0);
    chk("ar_raddr", ram_raddr, 0);
    @(negedge clk);
    reset_L = 1;

    // err_clr coinciding with a new overflow: set wins
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      tick();
    end
    cyc(1, 0, 0);
    tick();
    chk("sw_ovf", overflow_err, 1);
    cyc(1, 0, 1);
    tick();
    chk("sw_ovf_hold", overflow_err, 1);
    cyc(0, 0, 1);
    tick();
    chk("sw_ovf_clr", overflow_err, 0);
    chk("sw_count", count, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
